dma_master: RTL and testbench

- AXI4 initiator side of the DMA engine.
- Takes the DMAEN/DMASRC/DMADST/DMALEN configuration produced by the DMA register slave.
- Copies DMALEN 32-bit words from DMASRC to DMADST as repeated read-burst / write-burst pairs through a 16-entry staging buffer.
- Sits on the AXI bus as a master port beside the CPU masters; reports completion to the interrupt logic.

---
 rtl/dma_pkg.sv | 65 ++++++
 rtl/dma_buf.sv | 28 ++
 rtl/dma_master.sv | 231 +++++++++++++++++++++++
 tb/tb_dma_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types, constants and burst sizing helper for the DMA master.
// AXI width macros normally come from the AXI define file; defaults below
// apply only when that file has not already been included.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package dma_pkg;

    localparam int unsigned AXI_ID_W   = `AXI_IDS_BITS;
    localparam int unsigned AXI_ADDR_W = `AXI_ADDR_BITS;
    localparam int unsigned AXI_LEN_W  = `AXI_LEN_BITS;
    localparam int unsigned AXI_SIZE_W = `AXI_SIZE_BITS;
    localparam int unsigned AXI_DATA_W = `AXI_DATA_BITS;
    localparam int unsigned AXI_STRB_W = `AXI_STRB_BITS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WADDR = 3'd3,
        S_WDATA = 3'd4,
        S_WRESP = 3'd5,
        S_DONE  = 3'd6
    } dma_state_t;

    localparam logic [2:0]  DMA_SIZE_WORD  = 3'b010;
    localparam logic [1:0]  DMA_BURST_INCR = 2'b01;
    localparam logic [31:0] DMA_4K_MASK    = 32'h0000_0FFF;
    localparam logic [1:0]  DMA_RESP_OKAY  = 2'b00;

    // Words remaining before the next 4KB page boundary (1..1024).
    function automatic logic [31:0] words_to_4k(input logic [31:0] addr);
        return (32'h0000_1000 - (addr & DMA_4K_MASK)) >> 2;
    endfunction

    // Beats for the next burst: min(remaining, bmax, room in src page, room in dst page).
    function automatic logic [31:0] burst_beats(input logic [31:0] src,
                                                input logic [31:0] dst,
                                                input logic [31:0] rem,
                                                input int unsigned bmax);
        logic [31:0] n;
        n = rem;
        if (n > 32'(bmax))          n = 32'(bmax);
        if (n > words_to_4k(src))   n = words_to_4k(src);
        if (n > words_to_4k(dst))   n = words_to_4k(dst);
        return n;
    endfunction

endpackage

// File: rtl/dma_buf.sv
// Staging buffer: register array, synchronous write, combinational read.
module dma_buf
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = AXI_DATA_W,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Store one read beat per write strobe; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_master.sv
// AXI4 read/write burst engine copying DMALEN words from DMASRC to DMADST.
// Optional completion interrupt enabled by defining DMA_IRQ_EN.
module dma_master
    import dma_pkg::*;
#(
    parameter int unsigned           BURST_MAX = 16,
    parameter logic [AXI_ID_W-1:0]   MASTER_ID = AXI_ID_W'(2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DMAEN,
    input  logic [31:0]           DMASRC,
    input  logic [31:0]           DMADST,
    input  logic [31:0]           DMALEN,
    output logic [AXI_ID_W-1:0]   M_ARID,
    output logic [AXI_ADDR_W-1:0] M_ARAddr,
    output logic [AXI_LEN_W-1:0]  M_ARLen,
    output logic [AXI_SIZE_W-1:0] M_ARSize,
    output logic [1:0]            M_ARBurst,
    output logic                  M_ARValid,
    input  logic                  M_ARReady,
    input  logic [AXI_ID_W-1:0]   M_RID,
    input  logic [AXI_DATA_W-1:0] M_RData,
    input  logic [1:0]            M_RResp,
    input  logic                  M_RLast,
    input  logic                  M_RValid,
    output logic                  M_RReady,
    output logic [AXI_ID_W-1:0]   M_AWID,
    output logic [AXI_ADDR_W-1:0] M_AWAddr,
    output logic [AXI_LEN_W-1:0]  M_AWLen,
    output logic [AXI_SIZE_W-1:0] M_AWSize,
    output logic [1:0]            M_AWBurst,
    output logic                  M_AWValid,
    input  logic                  M_AWReady,
    output logic [AXI_DATA_W-1:0] M_WData,
    output logic [AXI_STRB_W-1:0] M_WStrb,
    output logic                  M_WLast,
    output logic                  M_WValid,
    input  logic                  M_WReady,
    input  logic [AXI_ID_W-1:0]   M_BID,
    input  logic [1:0]            M_BResp,
    input  logic                  M_BValid,
    output logic                  M_BReady,
    output logic                  DMA_done,
    output logic                  DMA_err
`ifdef DMA_IRQ_EN
    ,
    output logic                  DMA_irq,
    input  logic                  DMA_irq_clr
`endif
);

    localparam int unsigned BUF_AW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int unsigned CNT_W  = $clog2(BURST_MAX + 1);

    dma_state_t        state_q, state_n;
    logic [31:0]       src_q, src_n;
    logic [31:0]       dst_q, dst_n;
    logic [31:0]       rem_q, rem_n;
    logic [CNT_W-1:0]  beats_q, beats_n;
    logic [CNT_W-1:0]  rcnt_q, rcnt_n;
    logic [CNT_W-1:0]  wcnt_q, wcnt_n;
    logic [AXI_LEN_W-1:0] len_q;
    logic              err_n;
    logic              buf_we;
    logic [AXI_DATA_W-1:0] buf_rdata;

    // Fixed AXI attributes.
    assign M_ARID    = MASTER_ID;
    assign M_AWID    = MASTER_ID;
    assign M_ARSize  = AXI_SIZE_W'(DMA_SIZE_WORD);
    assign M_AWSize  = AXI_SIZE_W'(DMA_SIZE_WORD);
    assign M_ARBurst = DMA_BURST_INCR;
    assign M_AWBurst = DMA_BURST_INCR;
    assign M_WStrb   = {AXI_STRB_W{1'b1}};
    assign M_ARAddr  = AXI_ADDR_W'(src_q);
    assign M_AWAddr  = AXI_ADDR_W'(dst_q);
    assign M_ARLen   = len_q;
    assign M_AWLen   = len_q;

    // RID/BID are not checked (single master ID, one burst outstanding);
    // RLast is ignored because the beat counter decides the burst end.
    logic unused_ok;
    assign unused_ok = ^{M_RID, M_BID, M_RLast};

    dma_buf #(
        .DEPTH (BURST_MAX),
        .DW    (AXI_DATA_W),
        .AW    (BUF_AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (BUF_AW'(rcnt_q)),
        .wdata (M_RData),
        .raddr (BUF_AW'(wcnt_n)),
        .rdata (buf_rdata)
    );

    // State, datapath and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            rcnt_q    <= '0;
            wcnt_q    <= '0;
            len_q     <= '0;
            M_ARValid <= 1'b0;
            M_RReady  <= 1'b0;
            M_AWValid <= 1'b0;
            M_WValid  <= 1'b0;
            M_WLast   <= 1'b0;
            M_WData   <= '0;
            M_BReady  <= 1'b0;
            DMA_done  <= 1'b0;
            DMA_err   <= 1'b0;
        end else begin
            state_q   <= state_n;
            src_q     <= src_n;
            dst_q     <= dst_n;
            rem_q     <= rem_n;
            beats_q   <= beats_n;
            rcnt_q    <= rcnt_n;
            wcnt_q    <= wcnt_n;
            len_q     <= AXI_LEN_W'(beats_n - CNT_W'(1));
            M_ARValid <= (state_n == S_RADDR);
            M_RReady  <= (state_n == S_RDATA);
            M_AWValid <= (state_n == S_WADDR);
            M_WValid  <= (state_n == S_WDATA);
            M_WLast   <= (state_n == S_WDATA) && (wcnt_n == beats_n - CNT_W'(1));
            M_WData   <= buf_rdata;
            M_BReady  <= (state_n == S_WRESP);
            DMA_done  <= (state_n == S_DONE);
            DMA_err   <= err_n;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_n = state_q;
        src_n   = src_q;
        dst_n   = dst_q;
        rem_n   = rem_q;
        rcnt_n  = rcnt_q;
        wcnt_n  = wcnt_q;
        err_n   = DMA_err;
        buf_we  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                src_n = DMASRC;
                dst_n = DMADST;
                rem_n = DMALEN;
                err_n = 1'b0;
                if (DMAEN) begin
                    state_n = (DMALEN == 32'd0) ? S_DONE : S_RADDR;
                end
            end
            S_RADDR: begin
                if (M_ARReady) begin
                    state_n = S_RDATA;
                end
            end
            S_RDATA: begin
                if (M_RValid) begin
                    buf_we = 1'b1;
                    rcnt_n = rcnt_q + CNT_W'(1);
                    if (M_RResp != DMA_RESP_OKAY) begin
                        err_n = 1'b1;
                    end
                    if (rcnt_q == beats_q - CNT_W'(1)) begin
                        state_n = S_WADDR;
                    end
                end
            end
            S_WADDR: begin
                if (M_AWReady) begin
                    state_n = S_WDATA;
                end
            end
            S_WDATA: begin
                if (M_WReady) begin
                    wcnt_n = wcnt_q + CNT_W'(1);
                    if (wcnt_q == beats_q - CNT_W'(1)) begin
                        state_n = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                if (M_BValid) begin
                    if (M_BResp != DMA_RESP_OKAY) begin
                        err_n = 1'b1;
                    end
                    src_n   = src_q + (32'(beats_q) << 2);
                    dst_n   = dst_q + (32'(beats_q) << 2);
                    rem_n   = rem_q - 32'(beats_q);
                    rcnt_n  = '0;
                    wcnt_n  = '0;
                    state_n = (rem_n == 32'd0) ? S_DONE : S_RADDR;
                end
            end
            S_DONE: begin
                if (!DMAEN) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Burst size follows the address/length registers as they will be next cycle.
    assign beats_n = CNT_W'(burst_beats(src_n, dst_n, rem_n, BURST_MAX));

`ifdef DMA_IRQ_EN
    // Completion interrupt: set on entry to DONE, cleared by DMA_irq_clr (clear wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DMA_irq <= 1'b0;
        end else if (DMA_irq_clr) begin
            DMA_irq <= 1'b0;
        end else if ((state_n == S_DONE) && (state_q != S_DONE)) begin
            DMA_irq <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_master.sv
// Self-checking bench for dma_master: AXI slave model with optional stalls,
// burst-split reference computed from the page/length rules, data scoreboard.
module tb_dma_master;
    import dma_pkg::*;

    logic        clk, rst;
    logic        DMAEN;
    logic [31:0] DMASRC, DMADST, DMALEN;
    logic [3:0]  M_ARID, M_AWID, M_RID, M_BID;
    logic [31:0] M_ARAddr, M_AWAddr, M_RData, M_WData;
    logic [3:0]  M_ARLen, M_AWLen, M_WStrb;
    logic [2:0]  M_ARSize, M_AWSize;
    logic [1:0]  M_ARBurst, M_AWBurst, M_RResp, M_BResp;
    logic        M_ARValid, M_ARReady, M_RLast, M_RValid, M_RReady;
    logic        M_AWValid, M_AWReady, M_WLast, M_WValid, M_WReady;
    logic        M_BValid, M_BReady, DMA_done, DMA_err;
`ifdef DMA_IRQ_EN
    logic        DMA_irq, DMA_irq_clr;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] dmem [logic [31:0]];

    typedef struct {
        logic [31:0] src, dst, len;
        int          rerr, berr;
        bit          stall;
        int          exp_nb;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        int          n;
    } bst_t;

    dma_master dut (
        .clk(clk), .rst(rst), .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
        .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
        .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
        .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
        .M_RValid(M_RValid), .M_RReady(M_RReady),
        .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWSize(M_AWSize),
        .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
        .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid),
        .M_WReady(M_WReady), .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid),
        .M_BReady(M_BReady), .DMA_done(DMA_done), .DMA_err(DMA_err)
`ifdef DMA_IRQ_EN
        , .DMA_irq(DMA_irq), .DMA_irq_clr(DMA_irq_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ (a >> 3);
    endfunction

    task automatic slave_idle();
        M_ARReady = 1'b0; M_RValid = 1'b0; M_RData = '0; M_RResp = 2'b00; M_RLast = 1'b0;
        M_RID = 4'd2; M_AWReady = 1'b0; M_WReady = 1'b0; M_BValid = 1'b0; M_BResp = 2'b00;
        M_BID = 4'd2;
    endtask

    // One complete transfer against the slave model; abort=1 pulls reset during the write phase.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                            input int rerr, input int berr, input bit stall,
                            input int exp_nb_in, input bit exp_err_in, input bit abort);
        bst_t arq[$], awq[$], e;
        logic [31:0] a, b, r, n;
        int nb, exp_nb, cyc, budget, nar, nbdone, bad_words;
        bit exp_err, fin, b_last, aborted;
        bit rd_act, wr_act, b_pend;
        logic [31:0] rd_addr, wr_addr;
        int rd_n, rd_beat, rd_idx, wr_n, wr_beat;
        bit p_ar, p_aw, p_w;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0] p_arlen, p_awlen;
        logic p_wlast;

        // Reference burst list from the page/length rules.
        a = s; b = d; r = l;
        while (r != 0) begin
            n = r;
            if (n > 32'd16) n = 32'd16;
            if (n > (32'd4096 - 32'(a[11:0])) / 4) n = (32'd4096 - 32'(a[11:0])) / 4;
            if (n > (32'd4096 - 32'(b[11:0])) / 4) n = (32'd4096 - 32'(b[11:0])) / 4;
            arq.push_back('{a, int'(n)});
            awq.push_back('{b, int'(n)});
            a += n * 4; b += n * 4; r -= n;
        end
        nb      = arq.size();
        exp_nb  = (exp_nb_in >= 0) ? exp_nb_in : nb;
        exp_err = (exp_nb_in >= 0) ? exp_err_in
                : ((rerr >= 0 && rerr < nb) || (berr >= 0 && berr < nb));

        dmem.delete();
        nar = 0; nbdone = 0; fin = 0; b_last = 0; aborted = 0;
        rd_act = 0; wr_act = 0; b_pend = 0; rd_addr = '0; wr_addr = '0;
        rd_n = 0; rd_beat = 0; rd_idx = 0; wr_n = 0; wr_beat = 0;
        p_ar = 0; p_aw = 0; p_w = 0; p_araddr = '0; p_awaddr = '0; p_wdata = '0;
        p_arlen = '0; p_awlen = '0; p_wlast = 1'b0;

        @(negedge clk);
        DMASRC = s; DMADST = d; DMALEN = l; DMAEN = 1'b1;
        @(negedge clk);
        if (l == 0) begin
            chk("zero_len_done", 64'(DMA_done), 64'd1);
            chk("zero_len_no_ar", 64'(M_ARValid), 64'd0);
            fin = 1;
        end else begin
            chk("start_arvalid", 64'(M_ARValid), 64'd1);
        end

        cyc = 0;
        budget = 400 + 24 * int'(l);
        while (!fin && cyc < budget) begin
            if (abort && M_WValid) begin
                rst = 1'b0;
                #1;
                chk("rst_mid_valids", 64'({M_ARValid, M_RReady, M_AWValid, M_WValid, M_BReady, DMA_done}), 64'd0);
                slave_idle();
                DMAEN = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                fin = 1; aborted = 1;
            end else begin
                if (p_ar) chk("ar_stable", 64'({M_ARValid, M_ARAddr, M_ARLen}), 64'({1'b1, p_araddr, p_arlen}));
                if (p_aw) chk("aw_stable", 64'({M_AWValid, M_AWAddr, M_AWLen}), 64'({1'b1, p_awaddr, p_awlen}));
                if (p_w)  chk("w_stable",  64'({M_WValid, M_WData, M_WLast}), 64'({1'b1, p_wdata, p_wlast}));
                if (b_last) begin
                    chk("done_after_b", 64'(DMA_done), 64'd1);
                    fin = 1;
                end else if (DMA_done) begin
                    chk("done_early", 64'd1, 64'd0);
                    fin = 1;
                end
            end
            if (!fin) begin
                // Drive slave side for the coming edge.
                M_ARReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                M_RValid  = rd_act && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
                M_RData   = pat(rd_addr + 32'(rd_beat) * 32'd4);
                M_RLast   = (rd_beat == rd_n - 1);
                M_RResp   = (rd_idx == rerr) ? 2'b10 : 2'b00;
                M_AWReady = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                M_WReady  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                M_BValid  = b_pend && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
                M_BResp   = (nbdone == berr) ? 2'b10 : 2'b00;

                if (M_ARValid && M_ARReady) begin
                    nar++;
                    if (arq.size() == 0) chk("ar_extra", 64'd1, 64'd0);
                    else begin
                        e = arq.pop_front();
                        chk("ar_addr", 64'(M_ARAddr), 64'(e.a));
                        chk("ar_len", 64'(M_ARLen), 64'(e.n - 1));
                    end
                    chk("ar_fixed", 64'({M_ARID, M_ARSize, M_ARBurst}), 64'({4'd2, 3'b010, 2'b01}));
                    chk("ar_4k", 64'((32'(M_ARAddr[11:0]) + 32'(M_ARLen) * 32'd4 + 32'd4) <= 32'd4096), 64'd1);
                    rd_act = 1; rd_addr = M_ARAddr; rd_n = int'(M_ARLen) + 1; rd_beat = 0; rd_idx = nar - 1;
                end
                if (M_RValid && M_RReady) begin
                    rd_beat++;
                    if (rd_beat == rd_n) rd_act = 0;
                end
                if (M_AWValid && M_AWReady) begin
                    if (awq.size() == 0) chk("aw_extra", 64'd1, 64'd0);
                    else begin
                        e = awq.pop_front();
                        chk("aw_addr", 64'(M_AWAddr), 64'(e.a));
                        chk("aw_len", 64'(M_AWLen), 64'(e.n - 1));
                    end
                    chk("aw_fixed", 64'({M_AWID, M_AWSize, M_AWBurst}), 64'({4'd2, 3'b010, 2'b01}));
                    wr_act = 1; wr_addr = M_AWAddr; wr_n = int'(M_AWLen) + 1; wr_beat = 0;
                end
                if (M_WValid && M_WReady) begin
                    if (!wr_act) chk("w_without_aw", 64'd1, 64'd0);
                    else begin
                        chk("w_last", 64'(M_WLast), 64'(wr_beat == wr_n - 1));
                        chk("w_strb", 64'(M_WStrb), 64'hF);
                        dmem[wr_addr + 32'(wr_beat) * 32'd4] = M_WData;
                        wr_beat++;
                        if (wr_beat == wr_n) begin wr_act = 0; b_pend = 1; end
                    end
                end
                if (M_BValid && M_BReady) begin
                    b_pend = 0;
                    nbdone++;
                    if (nbdone == nb) b_last = 1;
                end

                p_ar = M_ARValid && !M_ARReady; p_araddr = M_ARAddr; p_arlen = M_ARLen;
                p_aw = M_AWValid && !M_AWReady; p_awaddr = M_AWAddr; p_awlen = M_AWLen;
                p_w  = M_WValid && !M_WReady;   p_wdata = M_WData;   p_wlast = M_WLast;
                @(negedge clk);
                cyc++;
            end
        end
        slave_idle();
        if (!fin) chk("timeout", 64'd1, 64'd0);
        if (aborted || !fin) begin
            DMAEN = 1'b0;
            return;
        end

        chk("err_flag", 64'(DMA_err), 64'(exp_err));
        chk("burst_count", 64'(nar), 64'(exp_nb));
        bad_words = 0;
        for (int i = 0; i < int'(l); i++) begin
            if (!dmem.exists(d + 32'(i) * 32'd4)) bad_words++;
            else if (dmem[d + 32'(i) * 32'd4] !== pat(s + 32'(i) * 32'd4)) bad_words++;
        end
        chk("data_words", 64'(bad_words), 64'd0);
`ifdef DMA_IRQ_EN
        chk("irq_set", 64'(DMA_irq), 64'd1);
        DMA_irq_clr = 1'b1;
        @(negedge clk);
        DMA_irq_clr = 1'b0;
        chk("irq_clr", 64'(DMA_irq), 64'd0);
`endif
        chk("done_held", 64'(DMA_done), 64'd1);
        DMAEN = 1'b0;
        @(negedge clk);
        chk("done_drop", 64'(DMA_done), 64'd0);
    endtask

    initial begin
        vec_t tbl[8];
        logic [31:0] rs, rd, rl;
        int re;

        tbl[0] = '{32'h0000_1000, 32'h0000_2000, 32'd3,  -1, -1, 1'b0, 1, 1'b0};
        tbl[1] = '{32'h0000_0000, 32'h0000_8000, 32'd40, -1, -1, 1'b0, 3, 1'b0};
        tbl[2] = '{32'h0000_0FF8, 32'h0000_3000, 32'd6,  -1, -1, 1'b0, 2, 1'b0};
        tbl[3] = '{32'h0000_0100, 32'h0000_5000, 32'd20, -1,  0, 1'b0, 2, 1'b1};
        tbl[4] = '{32'h0000_4000, 32'h0000_6000, 32'd0,  -1, -1, 1'b0, 0, 1'b0};
        tbl[5] = '{32'h0000_2FC0, 32'h0000_6FF0, 32'd20,  1, -1, 1'b1, 3, 1'b1};
        tbl[6] = '{32'h0000_1000, 32'h0000_2000, 32'd3,  -1, -1, 1'b1, 1, 1'b0};
        tbl[7] = '{32'h0000_0000, 32'h0000_8000, 32'd40, -1, -1, 1'b1, 3, 1'b0};

        rst = 1'b0; DMAEN = 1'b0; DMASRC = '0; DMADST = '0; DMALEN = '0;
`ifdef DMA_IRQ_EN
        DMA_irq_clr = 1'b0;
`endif
        slave_idle();
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'({M_ARValid, M_RReady, M_AWValid, M_WValid, M_BReady, DMA_done, DMA_err}), 64'd0);
        chk("rst_addr", 64'({M_ARAddr, M_AWAddr}), 64'd0);
        chk("rst_len", 64'({M_ARLen, M_AWLen}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_xfer(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].rerr, tbl[i].berr,
                     tbl[i].stall, tbl[i].exp_nb, tbl[i].exp_err, 1'b0);
        end

        // Reset during the write phase, then a clean restart.
        run_xfer(32'h0000_0100, 32'h0000_5000, 32'd20, -1, -1, 1'b0, -1, 1'b0, 1'b1);
        run_xfer(32'h0000_1000, 32'h0000_2000, 32'd3, -1, -1, 1'b0, 1, 1'b0, 1'b0);

        // Randomized transfers checked against the reference split and data pattern.
        for (int k = 0; k < 8; k++) begin
            rs = 32'($urandom_range(0, 32'hFFFF)) & 32'hFFFF_FFFC;
            rd = (32'($urandom_range(0, 32'hFFFF)) & 32'hFFFF_FFFC) | 32'h0001_0000;
            rl = 32'($urandom_range(1, 48));
            re = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            if (k[0]) run_xfer(rs, rd, rl, re, -1, 1'b1, -1, 1'b0, 1'b0);
            else      run_xfer(rs, rd, rl, -1, re, 1'b1, -1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
